// File: rtl/acc_out_port.sv
// rtl/acc_out_port.sv - accumulator output FIFO with valid/ready drain; optional sticky overflow under ACC_OUT_OVF_EN
module acc_out_port #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
`ifdef ACC_OUT_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push;

  // Occupancy comes from the counter alone, so pointer wrap never confuses full/empty.
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = enable & (~full | pop);

  // Storage, pointers and occupancy; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= D;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ACC_OUT_OVF_EN
  // Sticky record that a write was lost because the FIFO was full and not draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (enable & full & ~pop) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_out_port.sv
// tb/tb_acc_out_port.sv - randomized and directed bench for acc_out_port against a queue model
module tb_acc_out_port;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] D;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
  logic [2:0]       count;
`ifdef ACC_OUT_OVF_EN
  logic             overflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_ovf;

  acc_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef ACC_OUT_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the queue model.
  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ".valid"}, 32'(out_valid), 32'(sz != 0));
    check({tag, ".count"}, 32'(count), 32'(sz));
    check({tag, ".full"},  32'(full),  32'(sz == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    if (sz != 0) check({tag, ".data"}, 32'(out_data), 32'(model_q[0]));
`ifdef ACC_OUT_OVF_EN
    check({tag, ".ovf"}, 32'(overflow), 32'(model_ovf));
`endif
  endtask

  // One clock with the given inputs; model applies the accept rules, then everything is compared.
  task automatic step(input string tag, input logic e, input logic [WIDTH-1:0] d, input logic r);
    bit mpop, mpush;
    enable    = e;
    D         = d;
    out_ready = r;
    mpop  = (model_q.size() != 0) && r;
    mpush = e && ((model_q.size() < DEPTH) || mpop);
    if (e && !mpush) model_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (mpop) void'(model_q.pop_front());
    if (mpush) model_q.push_back(d);
    check_all(tag);
  endtask

  // Async reset: outputs must clear before any clock edge, then release between edges.
  task automatic do_reset(input string tag);
    enable    = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".data"},  32'(out_data),  32'd0);
    check({tag, ".count"}, 32'(count),     32'd0);
    check({tag, ".empty"}, 32'(empty),     32'd1);
    check({tag, ".full"},  32'(full),      32'd0);
`ifdef ACC_OUT_OVF_EN
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all({tag, ".rel"});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) step(tag, 1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    int rdy_pct;
    int en_pct;
    reset     = 1'b1;
    enable    = 1'b0;
    D         = '0;
    out_ready = 1'b0;
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Single write into empty, then held with out_ready low.
    step("t2.wr", 1'b1, 4'hA, 1'b0);
    check("t2.data_a", 32'(out_data), 32'hA);
    for (int i = 0; i < 5; i++) step("t2.hold", 1'b0, 4'h0, 1'b0);
    drain("t2.drain");

    // Fill, drop a fifth write, drain in order.
    for (int i = 1; i <= 4; i++) step("t3.fill", 1'b1, 4'(i), 1'b0);
    step("t3.drop", 1'b1, 4'h5, 1'b0);
    check("t3.full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t3.order", 32'(out_data), 32'(i));
      step("t3.drain", 1'b0, 4'h0, 1'b1);
    end
    do_reset("rst3");

    // Full with simultaneous write and pop.
    for (int i = 1; i <= 4; i++) step("t4.fill", 1'b1, 4'(i), 1'b0);
    step("t4.both", 1'b1, 4'h7, 1'b1);
    check("t4.count", 32'(count), 32'd4);
    drain("t4.drain");

    // Interleaved pushes and pops so the pointers wrap.
    step("t5.first", 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    for (int i = 0; i < 10; i++) step("t5.mix", 1'b1, 4'($urandom_range(0, 15)), 1'(i % 2));
    drain("t5.drain");

    // Ready held high: entry appears, then leaves on the next cycle.
    step("t6.wr", 1'b1, 4'hF, 1'b1);
    step("t6.pop", 1'b0, 4'h0, 1'b1);

    // Reset mid-run with three entries stored.
    for (int i = 0; i < 3; i++) step("t1.fill", 1'b1, 4'(i + 8), 1'b0);
    check("t1.pre", 32'(count), 32'd3);
    do_reset("t1.rst");

    // Random traffic with shifting bias so both full and empty are visited.
    for (int blk = 0; blk < 6; blk++) begin
      rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 80 : 50);
      en_pct  = (blk % 2 == 0) ? 70 : 40;
      for (int i = 0; i < 80; i++) begin
        step("rnd", 1'($urandom_range(0, 99) < en_pct), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 99) < rdy_pct));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
